fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient loading stage directly upstream of the FIR filter. It accepts N signed 16-bit tap coefficients over a valid/ready configuration port, followed by a 16-bit checksum word, and holds them in a shadow bank. Once the checksum verifies, it copies the shadow bank into the active bank that drives the filter's coefficient inputs. The copy is aligned to the filter's sample strobe, so a coefficient set never changes in the middle of a sample.

## Interface
- N, 10, number of filter taps (≥2)
- CW, 16, coefficient width in bits
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cfg_start  in  1  one-cycle request to begin a load
- cfg_abort  in  1  abandon the load in progress
- cfg_valid  in  1  cfg_data is valid
- cfg_data  in  CW  coefficient word, or the checksum word
- cfg_ready  out  1  block accepts cfg_data this cycle
- sample_en  in  1  filter sample strobe (same clk); commit point
- coeff_flat  out  N*CW  active bank; coeff_flat[CW*k +: CW] = tap k (tap 0 multiplies the newest sample)
- coeff_upd  out  1  one-cycle pulse: new active bank visible this cycle
- busy  out  1  state != IDLE
- err  out  1  checksum mismatch flag

## Operation
- Handshake: a word transfers when cfg_valid && cfg_ready at a rising edge. cfg_data must be held stable while cfg_valid=1 and cfg_ready=0.
- FSM states: IDLE, LOAD, CHK, COMMIT.
  - IDLE: cfg_ready=0. cfg_start → LOAD. The same edge clears idx, sum and err. cfg_valid in IDLE is ignored.
  - LOAD: cfg_ready=1. Each transfer writes shadow[idx]=cfg_data, sets sum += cfg_data and increments idx. The transfer with idx==N-1 → CHK.
  - CHK: cfg_ready=1. The next transfer is the checksum.
    - Equal to sum → COMMIT.
    - Otherwise err←1 → IDLE, and the active bank is unchanged.
  - COMMIT: cfg_ready=0. Waits for sample_en=1, then active←shadow, coeff_upd←1 for one cycle, → IDLE.
- Checksum arithmetic: sum is CW bits, unsigned, and wraps modulo 2^CW. Coefficients are treated as raw bits.
- cfg_start outside IDLE is ignored.
- cfg_abort in LOAD, CHK or COMMIT → IDLE on that edge.
  - The shadow contents are discarded, the active bank is unchanged and err is unchanged.
  - A transfer in the abort cycle is discarded.
- Simultaneous events:
  - cfg_abort with cfg_start in IDLE: abort wins, stay IDLE.
  - cfg_abort with sample_en in COMMIT: abort wins, no update.
- err stays set until the next accepted cfg_start.

## Timing
- Reset values (held while rst=1, and on the first edge after release):
  - State IDLE; cfg_ready=0, busy=0, err=0, coeff_upd=0.
  - coeff_flat: tap 0 = 16'h0001, all other taps = 0 (identity filter).
- cfg_ready and busy are decoded from the registered state only. They do not depend combinationally on any input.
- Minimum load: cfg_start edge, then N data edges, then 1 checksum edge, then ≥1 COMMIT edge. With zero wait and sample_en held high this is N+3 cycles from the cfg_start cycle to coeff_upd.
- sample_en in the same cycle as the checksum transfer does not commit. The earliest commit is the edge after entering COMMIT.
- On the commit edge coeff_flat changes to the new bank, and coeff_upd is high for exactly the following cycle, coincident with the new values.
- No partial update: coeff_flat only ever changes on a commit edge or on reset.
- Reset mid-operation (any state) restores all reset values, including the identity active bank.

## Test plan
- Reset: hold rst 2 cycles → coeff_flat tap0=0x0001, taps1..9=0; cfg_ready=0, busy=0, err=0, coeff_upd=0.
- Nominal load, N=10:
  - Stimulus: cfg_start; words 1..10 back-to-back; checksum 0x0037; sample_en first pulsed 3 cycles later.
  - Required: coeff_flat unchanged until that pulse; then taps = 1..10 and coeff_upd high for 1 cycle; busy low thereafter.
- Bad checksum:
  - Stimulus: words 1..10, checksum 0x0036.
  - Required: err=1, back to IDLE, coeff_flat unchanged. The next cfg_start clears err.
- Gaps and wrap:
  - Stimulus: cfg_valid toggles every other cycle; 10 × 0xFFFF; checksum 0xFFF6.
  - Required: only valid cycles counted; commit succeeds, all taps = 0xFFFF.
- Abort:
  - Stimulus A: cfg_abort after 4 words, then sample_en. Required: IDLE, no coeff_upd, bank unchanged.
  - Stimulus B: in COMMIT, cfg_abort together with sample_en. Required: no update.
  - Stimulus C: cfg_start during LOAD. Required: ignored, idx continues.
- Reset during COMMIT:
  - Stimulus: pending good bank, rst=1 with sample_en=1.
  - Required: no commit; identity bank, all outputs at reset values.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Coefficient loader for the FIR filter: collects N taps plus a checksum into a
// shadow bank and copies them to the active bank on a sample strobe once verified.
module fir_coeff_loader #(
    parameter int N  = 10,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_start,
    input  logic            cfg_abort,
    input  logic            cfg_valid,
    input  logic [CW-1:0]   cfg_data,
    output logic            cfg_ready,
    input  logic            sample_en,
    output logic [N*CW-1:0] coeff_flat,
    output logic            coeff_upd,
    output logic            busy,
    output logic            err
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [N*CW-1:0] IDENTITY = (N*CW)'(1);
    localparam logic [IW-1:0]   LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHK    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   sum;
    logic [CW-1:0]   shadow [N];
    logic            xfer;

    assign cfg_ready = (state == LOAD) || (state == CHK);
    assign busy      = (state != IDLE);
    assign xfer      = cfg_valid && cfg_ready;

    // Abort always wins over start, transfers and the commit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            sum        <= '0;
            err        <= 1'b0;
            coeff_upd  <= 1'b0;
            coeff_flat <= IDENTITY;
        end else begin
            coeff_upd <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start && !cfg_abort) begin
                        state <= LOAD;
                        idx   <= '0;
                        sum   <= '0;
                        err   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        shadow[idx] <= cfg_data;
                        sum         <= sum + cfg_data;
                        idx         <= idx + IW'(1);
                        if (idx == LAST_IDX) begin
                            state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                    end else if (xfer) begin
                        if (cfg_data == sum) begin
                            state <= COMMIT;
                        end else begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    if (cfg_abort) begin
                        state <= IDLE;
                    end else if (sample_en) begin
                        for (int k = 0; k < N; k++) begin
                            coeff_flat[CW*k +: CW] <= shadow[k];
                        end
                        coeff_upd <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader: nominal load, bad checksum,
// gapped valid with checksum wrap, aborts and reset during COMMIT.
module tb_fir_coeff_loader;

    localparam int N  = 10;
    localparam int CW = 16;
    localparam int W  = N * CW;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_abort;
    logic          cfg_valid;
    logic [CW-1:0] cfg_data;
    logic          cfg_ready;
    logic          sample_en;
    logic [W-1:0]  coeff_flat;
    logic          coeff_upd;
    logic          busy;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] bank_ident;
    logic [W-1:0] bank_seq;
    logic [W-1:0] bank_ones;

    fir_coeff_loader #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_abort  (cfg_abort),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .cfg_ready  (cfg_ready),
        .sample_en  (sample_en),
        .coeff_flat (coeff_flat),
        .coeff_upd  (coeff_upd),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle's inputs, then move to 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic s, input logic a, input logic v,
                                 input logic [CW-1:0] d, input logic se);
        cfg_start = s;
        cfg_abort = a;
        cfg_valid = v;
        cfg_data  = d;
        sample_en = se;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic loadSeq();
        for (int i = 1; i <= N; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, CW'(i), 1'b0);
        end
    endtask

    initial begin
        bank_ident = W'(1);
        bank_ones  = '1;
        for (int k = 0; k < N; k++) begin
            bank_seq[CW*k +: CW] = CW'(k + 1);
        end

        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("reset_bank", coeff_flat, bank_ident);
        checkFlag("reset_ready", cfg_ready, 1'b0);
        checkFlag("reset_busy", busy, 1'b0);
        checkFlag("reset_err", err, 1'b0);
        checkFlag("reset_upd", coeff_upd, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
        checkOutput("post_reset_bank", coeff_flat, bank_ident);
        checkFlag("idle_ignores_valid", busy, 1'b0);

        $display("[TB] nominal load with cfg_start during LOAD");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkFlag("load_busy", busy, 1'b1);
        checkFlag("load_ready", cfg_ready, 1'b1);
        for (int i = 1; i <= N; i++) begin
            applyStimulus(i == 5, 1'b0, 1'b1, CW'(i), 1'b0);
        end
        checkFlag("chk_ready", cfg_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0037, 1'b0);
        checkFlag("commit_ready", cfg_ready, 1'b0);
        checkFlag("commit_busy", busy, 1'b1);
        checkOutput("commit_wait_bank", coeff_flat, bank_ident);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("before_strobe_bank", coeff_flat, bank_ident);
        checkFlag("before_strobe_upd", coeff_upd, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("nominal_bank", coeff_flat, bank_seq);
        checkFlag("nominal_upd", coeff_upd, 1'b1);
        checkFlag("nominal_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkFlag("upd_one_cycle", coeff_upd, 1'b0);
        checkOutput("nominal_bank_hold", coeff_flat, bank_seq);

        $display("[TB] bad checksum");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        loadSeq();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0036, 1'b0);
        checkFlag("bad_err", err, 1'b1);
        checkFlag("bad_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("bad_bank", coeff_flat, bank_seq);
        checkFlag("bad_upd", coeff_upd, 1'b0);
        checkFlag("err_holds", err, 1'b1);

        $display("[TB] gapped valid with checksum wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkFlag("start_clears_err", err, 1'b0);
        for (int i = 0; i < 2 * N; i++) begin
            if (i % 2 == 0) applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);
            else            applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        end
        checkFlag("gap_in_chk", cfg_ready, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFF6, 1'b1);
        checkFlag("chk_strobe_no_upd", coeff_upd, 1'b0);
        checkOutput("chk_strobe_bank", coeff_flat, bank_seq);
        checkFlag("gap_commit_busy", busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("wrap_bank", coeff_flat, bank_ones);
        checkFlag("wrap_upd", coeff_upd, 1'b1);
        checkFlag("wrap_err", err, 1'b0);

        $display("[TB] abort in LOAD");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 16'h0007, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0007, 1'b0);
        checkFlag("abortA_busy", busy, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkFlag("abortA_upd", coeff_upd, 1'b0);
        checkOutput("abortA_bank", coeff_flat, bank_ones);

        $display("[TB] abort with sample_en in COMMIT");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        loadSeq();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0037, 1'b0);
        checkFlag("abortB_in_commit", busy, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b1);
        checkFlag("abortB_busy", busy, 1'b0);
        checkFlag("abortB_upd", coeff_upd, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("abortB_bank", coeff_flat, bank_ones);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
        checkFlag("abort_beats_start", busy, 1'b0);

        $display("[TB] reset during COMMIT");
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        loadSeq();
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0037, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("rst_commit_bank", coeff_flat, bank_ident);
        checkFlag("rst_commit_upd", coeff_upd, 1'b0);
        checkFlag("rst_commit_busy", busy, 1'b0);
        checkFlag("rst_commit_ready", cfg_ready, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("rst_commit_after", coeff_flat, bank_ident);
        checkFlag("rst_commit_after_upd", coeff_upd, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
